fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the synchronous instruction memory for the IF stage of the pipelined RISC-V core. Owns the program counter, drives the memory word address, and tracks the one-cycle read latency. Handles decode back-pressure by replaying the held address, and redirects from execute by flushing the in-flight fetch. Presents a valid/PC/instruction triple to the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- imem_addr  out  32  word index to instruction memory, {22'b0, pc[11:2]}; combinational from controller state
- imem_instr  in  32  instruction memory read data; valid one cycle after imem_addr is presented
- stall  in  1  decode cannot accept this cycle; the current if_* triple must be held
- redirect_valid  in  1  branch/jump taken; overrides stall
- redirect_pc  in  32  redirect target byte address; bits [1:0] ignored (treated as 0)
- if_valid  out  1  if_pc/if_instr hold a live instruction
- if_pc  out  32  byte PC of if_instr
- if_instr  out  32  fetched instruction; 32'h0000_0013 (NOP) whenever if_valid=0

## Operation
- State: FSM {BOOT, RUN, HOLD}; req_pc_q = PC whose data is on imem_instr this cycle; next_pc = address presented this cycle.
- Reset: FSM=BOOT, req_pc_q=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=NOP, imem_addr=RESET_PC[11:2].
- BOOT (one cycle): present RESET_PC; if_valid=0; go RUN with req_pc_q=RESET_PC. A redirect in BOOT presents redirect_pc instead.
- RUN: if_valid=1, if_pc=req_pc_q, if_instr=imem_instr.
  - No stall, no redirect: present req_pc_q+4; req_pc_q<=req_pc_q+4.
  - stall=1: present req_pc_q (replay); stay on the same PC; go HOLD.
- HOLD: same outputs as RUN (memory re-reads the same word). Present req_pc_q while stall=1. Go RUN presenting req_pc_q+4 when stall=0.
- Redirect (any state, highest priority): if_valid forced 0 that cycle (kill). Present {redirect_pc[31:2],2'b00}; req_pc_q<=that value; go RUN. stall is ignored that cycle.
- Arithmetic: PC is 32-bit, wraps modulo 2^32. Memory index wraps modulo 1024 words (pc[11:2]); no out-of-range detection.
- Reset asserted mid-operation: next edge returns to the reset state regardless of stall or redirect. In-flight data is discarded.

## Timing
- Fetch latency: 1 cycle from address presentation to if_valid.
- Redirect penalty: exactly 1 bubble cycle (if_valid=0), then the target instruction.
- Stall release: no bubble. The held instruction is consumed on the first cycle with stall=0; the next instruction appears on the following cycle.
- Throughput: 1 instruction/cycle with no stall or redirect.
- if_valid and if_instr depend combinationally on redirect_valid (kill path). imem_addr depends combinationally on stall and redirect_valid.

## Configuration
- FETCH_PERF_EN defined: adds three outputs, each 32-bit and wrapping, cleared by reset.
  - perf_fetched: increments when if_valid=1, stall=0 and redirect_valid=0.
  - perf_stall_cycles: increments when if_valid=1 and stall=1.
  - perf_redirects: increments when redirect_valid=1.
- FETCH_PERF_EN undefined: the ports and counters do not exist. Functional behaviour is identical.

## Test plan
- Reset then free run, RESET_PC=0, mem[i]=i: if_valid=0 on cycle 1 after reset. Cycles 2,3,4 show (pc,instr) = (0,0), (4,1), (8,2).
- Stall for 3 cycles while showing pc=8: if_pc=8 and if_instr=2 held for all 3 cycles, then pc=12 the cycle after release with no bubble.
- redirect_valid=1, redirect_pc=0x40 while showing pc=8: if_valid=0 that cycle; next cycle pc=0x40, instr=mem[16].
- Redirect and stall in the same cycle, redirect_pc=0x103: stall ignored; next cycle pc=0x100.
- PC 0xFFC with mem[1023] then sequential: next is pc=0x1000, instr=mem[0]. Reset asserted during HOLD returns to BOOT with if_valid=0.
- FETCH_PERF_EN: run 10 fetches, 3 stall cycles, 1 redirect; expect perf_fetched=10, perf_stall_cycles=3, perf_redirects=1.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
//   IF-stage sequencer for the synchronous instruction memory. Owns the PC,
//   drives the memory word address, tracks the one-cycle read latency,
//   replays the held address under decode back-pressure and kills the
//   in-flight fetch on an execute redirect.
//
// Optional feature macro: FETCH_PERF_EN adds three wrapping 32-bit
//   performance counters (perf_fetched, perf_stall_cycles, perf_redirects).
//
// Ports
//   clock          in   system clock, posedge
//   reset          in   synchronous, active-high
//   imem_addr      out  word index {22'b0, pc[11:2]} presented this cycle
//   imem_instr     in   memory data for the address presented last cycle
//   stall          in   decode cannot accept the current if_* triple
//   redirect_valid in   taken branch/jump, overrides stall
//   redirect_pc    in   redirect byte address, bits [1:0] ignored
//   if_valid       out  if_pc/if_instr carry a live instruction
//   if_pc          out  byte PC of if_instr
//   if_instr       out  fetched instruction, NOP when if_valid=0
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  // PC whose data is on imem_instr this cycle.
  logic [31:0] req_pc_q, req_pc_d;
  // Byte address presented to memory this cycle.
  logic [31:0] next_pc;
  logic [31:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'd3;

  always_comb begin
    state_d  = state_q;
    next_pc  = req_pc_q;
    if (redirect_valid) begin
      next_pc = redirect_aligned;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          next_pc = RESET_PC;
          state_d = RUN;
        end
        RUN, HOLD: begin
          if (stall) begin
            // Replay: memory re-reads the same word while decode is blocked.
            next_pc = req_pc_q;
            state_d = HOLD;
          end else begin
            next_pc = req_pc_q + 32'd4;
            state_d = RUN;
          end
        end
        default: begin
          next_pc = RESET_PC;
          state_d = BOOT;
        end
      endcase
    end
    req_pc_d = next_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= BOOT;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign imem_addr = {22'b0, next_pc[11:2]};

  // Redirect kills whatever is being fetched this cycle.
  assign if_valid = (state_q == RUN || state_q == HOLD) && !redirect_valid;
  assign if_pc    = req_pc_q;
  assign if_instr = if_valid ? imem_instr : NOP;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q, perf_redirects_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_stall_q     <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (if_valid && !stall && !redirect_valid)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (if_valid && stall)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid)
        perf_redirects_q <= perf_redirects_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
`endif

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory, mem[i] = i.
  logic [31:0] mem [0:1023];
  logic [9:0]  mem_idx;
  assign mem_idx = imem_addr[9:0];
  initial for (int i = 0; i < 1024; i++) mem[i] = i;
  always @(posedge clock) imem_instr <= mem[mem_idx];

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // st rv rpc | valid pc instr addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    32'h13,  32'h0};   // BOOT
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,    32'h0,   32'h1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,    32'h1,   32'h2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,    32'h2,   32'h2};   // stall 1
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,    32'h2,   32'h2};   // stall 2
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,    32'h2,   32'h2};   // stall 3
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,    32'h2,   32'h3};   // release
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,    32'h3,   32'h4};
    vecs[8]  = '{1'b0, 1'b1, 32'h40,  1'b0, 32'h10,   32'h13,  32'h10};  // redirect
    vecs[9]  = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h40,   32'h13,  32'h40};  // redirect+stall
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100,  32'h40,  32'h41};
    vecs[11] = '{1'b0, 1'b1, 32'hFFC, 1'b0, 32'h104,  32'h13,  32'h3FF};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hFFC,  32'h3FF, 32'h0};   // index wrap
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1000, 32'h0,   32'h1};
    vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1004, 32'h1,   32'h1};
    vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1004, 32'h1,   32'h1};   // HOLD

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].st;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #2;
      check($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].valid});
      check($sformatf("row%0d if_pc", i), if_pc, vecs[i].pc);
      check($sformatf("row%0d if_instr", i), if_instr, vecs[i].instr);
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      @(posedge clock);
      #1;
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd7);
    check("perf_stall_cycles", perf_stall_cycles, 32'd5);
    check("perf_redirects", perf_redirects, 32'd3);
`endif

    // Reset during HOLD, with stall and redirect both active.
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clock);
    #1 reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    #2;
    check("rst_hold if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_hold if_pc", if_pc, 32'h0);
    check("rst_hold if_instr", if_instr, 32'h13);
    check("rst_hold imem_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst perf_fetched", perf_fetched, 32'd0);
`endif
    @(posedge clock);
    #3;
    check("post_rst if_valid", {31'b0, if_valid}, 32'd1);
    check("post_rst if_pc", if_pc, 32'h0);
    check("post_rst if_instr", if_instr, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
